// File: rtl/assoc_cache.sv
// Fully-associative cache with byte-masked writes, invalidate/flush commands,
// LRU or xorshift32 random replacement and saturating hit/miss counters.
module assoc_cache #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned AGE_BITS      = 4,
    parameter int unsigned REPL_MODE     = 0,
    parameter logic [31:0] SEED          = 32'd314156
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_cmd,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    input  logic [WIDTH/8-1:0]       req_be,
    output logic                     rsp_valid,
    output logic                     rsp_hit,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned BW = WIDTH / 8;

    localparam logic [1:0] CmdRead  = 2'd0;
    localparam logic [1:0] CmdWrite = 2'd1;
    localparam logic [1:0] CmdInval = 2'd2;
    localparam logic [1:0] CmdFlush = 2'd3;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e                   state_q;
    logic [IW-1:0]            flush_idx_q;
    logic [31:0]              rnd_q;
    logic                     rsp_valid_q, rsp_hit_q;
    logic [WIDTH-1:0]         rsp_data_q;
    logic [15:0]              hit_cnt_q, miss_cnt_q;

    logic [ADDRESS_WIDTH-1:0] key_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] key_d [DEPTH];
    logic [WIDTH-1:0]         data_q [DEPTH];
    logic [WIDTH-1:0]         data_d [DEPTH];
    logic [AGE_BITS-1:0]      age_q [DEPTH];
    logic [AGE_BITS-1:0]      age_d [DEPTH];
    logic [DEPTH-1:0]         valid_q, valid_d;

    logic [DEPTH-1:0]         match;
    logic                     hit;
    logic [IW-1:0]            hit_idx;
    logic [IW-1:0]            victim, lru_idx, free_idx;
    logic [AGE_BITS-1:0]      lru_age;
    logic [WIDTH-1:0]         merged;
    logic                     accept;
    logic                     touch;
    logic [IW-1:0]            touch_idx;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    assign req_ready  = (state_q == StIdle);
    assign accept     = req_valid && (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_hit    = rsp_hit_q;
    assign rsp_data   = rsp_data_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Key lookup; a hit requires exactly one matching valid entry.
    always_comb begin
        match   = '0;
        hit_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match[i] = valid_q[i] && (key_q[i] == req_addr);
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = IW'(i);
        end
        hit = (match != '0) && ((match & (match - 1'b1)) == '0);
    end

    // Victim: lowest invalid entry first, else oldest (lowest index on tie) or random.
    always_comb begin
        lru_idx  = '0;
        lru_age  = age_q[0];
        free_idx = '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (age_q[i] > lru_age) begin
                lru_idx = IW'(i);
                lru_age = age_q[i];
            end
        end
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IW'(i);
        end
        if (!(&valid_q))          victim = free_idx;
        else if (REPL_MODE == 0)  victim = lru_idx;
        else                      victim = rnd_q[IW-1:0];
    end

    // Byte-masked merge of write data into the hitting entry.
    always_comb begin
        merged = data_q[hit_idx];
        for (int b = 0; b < int'(BW); b++) begin
            if (req_be[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
        end
    end

    // Next-state of the entry array: command effects, flush sweep and age touch.
    always_comb begin
        key_d     = key_q;
        data_d    = data_q;
        valid_d   = valid_q;
        age_d     = age_q;
        touch     = 1'b0;
        touch_idx = '0;
        if (accept) begin
            unique case (req_cmd)
                CmdRead: begin
                    if (hit) begin
                        touch     = 1'b1;
                        touch_idx = hit_idx;
                    end
                end
                CmdWrite: begin
                    if (hit) begin
                        data_d[hit_idx] = merged;
                        touch           = 1'b1;
                        touch_idx       = hit_idx;
                    end else if (&req_be) begin
                        key_d[victim]   = req_addr;
                        data_d[victim]  = req_wdata;
                        valid_d[victim] = 1'b1;
                        touch           = 1'b1;
                        touch_idx       = victim;
                    end
                end
                CmdInval: begin
                    if (hit) valid_d[hit_idx] = 1'b0;
                end
                CmdFlush: ;
            endcase
        end else if (state_q == StFlush) begin
            valid_d[flush_idx_q] = 1'b0;
        end
        if (touch) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (IW'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (valid_q[i] && (age_q[i] != '1)) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Entry array storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            data_q  <= data_d;
            age_q   <= age_d;
        end
    end

    // Control FSM with registered response, counters and free-running xorshift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            flush_idx_q <= '0;
            rnd_q       <= SEED;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rnd_q       <= xorshift32(rnd_q);
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (req_cmd == CmdFlush) begin
                            state_q     <= StFlush;
                            flush_idx_q <= '0;
                            hit_cnt_q   <= '0;
                            miss_cnt_q  <= '0;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_hit_q   <= hit;
                            if (hit) begin
                                rsp_data_q <= (req_cmd == CmdWrite) ? merged : data_q[hit_idx];
                            end
                            if (req_cmd != CmdInval) begin
                                if (hit) begin
                                    if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                                end else begin
                                    if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                                end
                            end
                        end
                    end
                end
                StFlush: begin
                    if (flush_idx_q == IW'(DEPTH - 1)) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        flush_idx_q <= flush_idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: one LRU instance and one random-replacement instance.
module tb_assoc_cache;

    localparam logic [1:0] RD  = 2'd0;
    localparam logic [1:0] WR  = 2'd1;
    localparam logic [1:0] INV = 2'd2;
    localparam logic [1:0] FL  = 2'd3;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } exp_t;

    logic        clk, reset_n;
    logic        v0, rdy0, rv0, rh0, v1, rdy1, rv1, rh1;
    logic [1:0]  c0, c1;
    logic [7:0]  a0, a1;
    logic [31:0] wd0, rd0, wd1, rd1;
    logic [3:0]  be0, be1;
    logic [15:0] hc0, mc0, hc1, mc1;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    int          total, bad;
    logic [31:0] rnd_model, last_rnd;
    int          low_cycles;
    bit          seen_rise;
    logic [1:0]  vic;

    assoc_cache #(.DEPTH(4), .WIDTH(32), .ADDRESS_WIDTH(8), .AGE_BITS(4), .REPL_MODE(0),
                  .SEED(32'd314156)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(v0), .req_ready(rdy0), .req_cmd(c0),
        .req_addr(a0), .req_wdata(wd0), .req_be(be0), .rsp_valid(rv0), .rsp_hit(rh0),
        .rsp_data(rd0), .hit_count(hc0), .miss_count(mc0)
    );

    assoc_cache #(.DEPTH(4), .WIDTH(32), .ADDRESS_WIDTH(8), .AGE_BITS(4), .REPL_MODE(1),
                  .SEED(32'd314156)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_ready(rdy1), .req_cmd(c1),
        .req_addr(a1), .req_wdata(wd1), .req_be(be1), .rsp_valid(rv1), .rsp_hit(rh1),
        .rsp_data(rd1), .hit_count(hc1), .miss_count(mc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // Reference xorshift32 state, stepping on every rising edge out of reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rnd_model <= 32'd314156;
        else          rnd_model <= xs32(rnd_model);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitors: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rv0) begin
            if (q0.size() == 0) begin
                check_eq("dut0_spurious_rsp", 64'd1, 64'd0);
            end else begin
                e0 = q0.pop_front();
                check_eq("dut0_rsp_hit", {63'd0, rh0}, {63'd0, e0.hit});
                check_eq("dut0_rsp_data", {32'd0, rd0}, {32'd0, e0.data});
            end
        end
        if (rv1) begin
            if (q1.size() == 0) begin
                check_eq("dut1_spurious_rsp", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check_eq("dut1_rsp_hit", {63'd0, rh1}, {63'd0, e1.hit});
                check_eq("dut1_rsp_data", {32'd0, rd1}, {32'd0, e1.data});
            end
        end
    end

    // Present one request to the selected DUT; returns #1 after the accept edge.
    task automatic send(input bit sel, input logic [1:0] cmd, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit exp_rsp,
                        input bit exp_hit, input logic [31:0] exp_data);
        int   n;
        exp_t e;
        n = 0;
        while (!(sel ? rdy1 : rdy0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 100) check_eq("ready_timeout", 64'd0, 64'd1);
        e.hit  = exp_hit;
        e.data = exp_data;
        if (sel) begin
            v1 = 1'b1; c1 = cmd; a1 = addr; wd1 = wdata; be1 = be;
            if (exp_rsp) q1.push_back(e);
        end else begin
            v0 = 1'b1; c0 = cmd; a0 = addr; wd0 = wdata; be0 = be;
            if (exp_rsp) q0.push_back(e);
        end
        last_rnd = rnd_model;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0;
        v0 = 0; c0 = 0; a0 = 0; wd0 = 0; be0 = 0;
        v1 = 0; c1 = 0; a1 = 0; wd1 = 0; be1 = 0;
        repeat (2) @(negedge clk);
        check_eq("reset_rsp_valid", {63'd0, rv0}, 64'd0);
        check_eq("reset_rsp_hit", {63'd0, rh0}, 64'd0);
        check_eq("reset_rsp_data", {32'd0, rd0}, 64'd0);
        check_eq("reset_ready", {63'd0, rdy0}, 64'd1);
        check_eq("reset_counts", {32'd0, hc0, mc0}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic miss, allocate, hit, byte merge, partial-be miss.
        send(0, RD, 8'h10, 32'h0, 4'h0, 1, 0, 32'h0);
        check_eq("miss_count_1", {48'd0, mc0}, 64'd1);
        send(0, WR, 8'h10, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0);
        send(0, RD, 8'h10, 32'h0, 4'h0, 1, 1, 32'hDEADBEEF);
        check_eq("hit_count_1", {48'd0, hc0}, 64'd1);
        send(0, WR, 8'h10, 32'h11223344, 4'h5, 1, 1, 32'hDE22BE44);
        send(0, RD, 8'h10, 32'h0, 4'h0, 1, 1, 32'hDE22BE44);
        send(0, WR, 8'h20, 32'hCAFEF00D, 4'h3, 1, 0, 32'h0);
        send(0, RD, 8'h20, 32'h0, 4'h0, 1, 0, 32'h0);
        check_eq("counts_after_basic", {32'd0, hc0, mc0}, {32'd0, 16'd3, 16'd4});

        // LRU: free the slot, fill 1..4, touch 1, allocate 5 -> 2 is evicted.
        send(0, INV, 8'h10, 32'h0, 4'h0, 1, 1, 32'hDE22BE44);
        for (int k = 1; k <= 4; k++) begin
            send(0, WR, 8'(k), 32'h100 + 32'(k), 4'hF, 1, 0, 32'h0);
        end
        send(0, RD, 8'h01, 32'h0, 4'h0, 1, 1, 32'h101);
        send(0, WR, 8'h05, 32'h105, 4'hF, 1, 0, 32'h0);
        send(0, RD, 8'h02, 32'h0, 4'h0, 1, 0, 32'h0);
        send(0, RD, 8'h01, 32'h0, 4'h0, 1, 1, 32'h101);
        send(0, RD, 8'h03, 32'h0, 4'h0, 1, 1, 32'h103);
        send(0, RD, 8'h04, 32'h0, 4'h0, 1, 1, 32'h104);
        send(0, RD, 8'h05, 32'h0, 4'h0, 1, 1, 32'h105);

        // Back-to-back write/read and invalidate/read.
        send(0, WR, 8'h30, 32'hA5A5A5A5, 4'hF, 1, 0, 32'h0);
        send(0, RD, 8'h30, 32'h0, 4'h0, 1, 1, 32'hA5A5A5A5);
        send(0, INV, 8'h30, 32'h0, 4'h0, 1, 1, 32'hA5A5A5A5);
        send(0, RD, 8'h30, 32'h0, 4'h0, 1, 0, 32'h0);
        send(0, WR, 8'h31, 32'h31313131, 4'hF, 1, 0, 32'h0);

        // Flush of a full cache.
        send(0, FL, 8'h00, 32'h0, 4'h0, 1, 0, 32'h0);
        low_cycles = 0;
        seen_rise  = 0;
        for (int i = 0; i < 20 && !seen_rise; i++) begin
            @(negedge clk);
            if (rdy0) begin
                seen_rise = 1;
                check_eq("flush_rsp_at_ready_rise", {63'd0, rv0}, 64'd1);
            end else begin
                low_cycles++;
            end
        end
        check_eq("flush_ready_returned", {63'd0, seen_rise}, 64'd1);
        check_eq("flush_ready_low_cycles", 64'(low_cycles), 64'd4);
        check_eq("flush_counts_clear", {32'd0, hc0, mc0}, 64'd0);
        send(0, RD, 8'h31, 32'h0, 4'h0, 1, 0, 32'h0);
        send(0, RD, 8'h01, 32'h0, 4'h0, 1, 0, 32'h0);
        check_eq("miss_count_after_flush", {48'd0, mc0}, 64'd2);

        // Reset during the second flush cycle aborts it silently.
        send(0, WR, 8'h50, 32'h50505050, 4'hF, 1, 0, 32'h0);
        send(0, RD, 8'h50, 32'h0, 4'h0, 1, 1, 32'h50505050);
        send(0, FL, 8'h00, 32'h0, 4'h0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_eq("abort_ready", {63'd0, rdy0}, 64'd1);
        check_eq("abort_counts", {32'd0, hc0, mc0}, 64'd0);
        send(0, RD, 8'h50, 32'h0, 4'h0, 1, 0, 32'h0);

        // Random replacement: the evicted slot follows the xorshift state at accept.
        for (int k = 0; k < 4; k++) begin
            send(1, WR, 8'h41 + 8'(k), 32'hC000_0041 + 32'(k), 4'hF, 1, 0, 32'h0);
        end
        send(1, WR, 8'h45, 32'hC000_0045, 4'hF, 1, 0, 32'h0);
        vic = last_rnd[1:0];
        for (int k = 0; k < 4; k++) begin
            if (2'(k) == vic) send(1, RD, 8'h41 + 8'(k), 32'h0, 4'h0, 1, 0, 32'h0);
            else send(1, RD, 8'h41 + 8'(k), 32'h0, 4'h0, 1, 1, 32'hC000_0041 + 32'(k));
        end
        send(1, RD, 8'h45, 32'h0, 4'h0, 1, 1, 32'hC000_0045);
        check_eq("rnd_counts", {32'd0, hc1, mc1}, {32'd0, 16'd4, 16'd6});

        repeat (3) @(negedge clk);
        check_eq("sb0_drained", 64'(q0.size()), 64'd0);
        check_eq("sb1_drained", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
